arbitro_wrr: RTL and testbench



---
 rtl/arbitro_wrr_pkg.sv | 27 ++
 rtl/arbitro_wrr_rr_buscador.sv | 27 ++
 rtl/arbitro_wrr.sv | 135 +++++++++++++
 tb/tb_arbitro_wrr.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_wrr_pkg.sv
// qos_pkg: shared types and constants for the arbitro_wrr weighted
// round-robin arbiter (class index, FSM states, default weights, one-hot helper).
package qos_pkg;

  localparam int NUM_CLASES = 4;

  // Default consecutive-transfer credits per class (highest share to class 0)
  localparam int W0_DEF = 4;
  localparam int W1_DEF = 3;
  localparam int W2_DEF = 2;
  localparam int W3_DEF = 1;

  typedef logic [1:0] clase_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } estado_t;

  function automatic logic [NUM_CLASES-1:0] onehot(input clase_t idx);
    logic [NUM_CLASES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arbitro_wrr_rr_buscador.sv
// rr_buscador: combinational rotating-priority search. Looks at start+1,
// start+2, start+3 and finally start itself, returning the first eligible class.
module rr_buscador
  import qos_pkg::*;
(
  input  logic [NUM_CLASES-1:0] elig_i,
  input  clase_t                start_i,
  output logic                  found_o,
  output clase_t                idx_o
);

  // Walk offsets from farthest to nearest so the nearest eligible class wins
  always_comb begin
    clase_t cand;
    found_o = 1'b0;
    idx_o   = start_i;
    cand    = start_i;
    for (int k = NUM_CLASES; k >= 1; k--) begin
      cand = start_i + clase_t'(k);
      if (elig_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_wrr.sv
// arbitro_wrr: weighted round-robin arbiter feeding the class-FIFO to
// main-FIFO connector. Drives a registered one-hot GRAND and POPDATOCF strobe.
// Optional feature macro: QOS_STRICT_PRIO_EN (class 0 becomes strict priority).
module arbitro_wrr
  import qos_pkg::*;
#(
  parameter int W0         = W0_DEF,
  parameter int W1         = W1_DEF,
  parameter int W2         = W2_DEF,
  parameter int W3         = W3_DEF,
  parameter int CRED_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_L,
  input  logic [NUM_CLASES-1:0] FIFO_EMPTY,
  input  logic [NUM_CLASES-1:0] FIFO_ALMOST_EMPTY,
  input  logic                  FIFOP_ALMOST_FULL,
  output logic [NUM_CLASES-1:0] GRAND,
  output logic                  POPDATOCF
);

  // A zero weight still deserves one transfer per round; the grant cycle
  // itself consumes one transfer, so the counter loads weight-1.
  localparam logic [CRED_WIDTH-1:0] CARGA0 = CRED_WIDTH'(((W0 == 0) ? 1 : W0) - 1);
  localparam logic [CRED_WIDTH-1:0] CARGA1 = CRED_WIDTH'(((W1 == 0) ? 1 : W1) - 1);
  localparam logic [CRED_WIDTH-1:0] CARGA2 = CRED_WIDTH'(((W2 == 0) ? 1 : W2) - 1);
  localparam logic [CRED_WIDTH-1:0] CARGA3 = CRED_WIDTH'(((W3 == 0) ? 1 : W3) - 1);

  function automatic logic [CRED_WIDTH-1:0] cargaDe(input clase_t c);
    case (c)
      2'd0:    return CARGA0;
      2'd1:    return CARGA1;
      2'd2:    return CARGA2;
      default: return CARGA3;
    endcase
  endfunction

  estado_t                estado_q, estado_d;
  clase_t                 cur_q, cur_d;
  logic [CRED_WIDTH-1:0]  credit_q, credit_d;
  logic [NUM_CLASES-1:0]  grand_q, grand_d;
  logic                   pop_q, pop_d;

  logic [NUM_CLASES-1:0]  elig;
  clase_t                 searchStart;
  logic                   found;
  clase_t                 foundIdx;

  // A FIFO popped this cycle while holding its last word still shows
  // non-empty flags, so it must not be popped again until they update.
  assign elig = ~FIFO_EMPTY & ~({NUM_CLASES{pop_q}} & grand_q & FIFO_ALMOST_EMPTY);

`ifdef QOS_STRICT_PRIO_EN
  clase_t resume_q, resume_d;
  // While class 0 holds the pointer, round-robin continues from the class it preempted
  assign searchStart = (cur_q == 2'd0) ? resume_q : cur_q;
`else
  assign searchStart = cur_q;
`endif

  rr_buscador u_buscador (
    .elig_i  (elig),
    .start_i (searchStart),
    .found_o (found),
    .idx_o   (foundIdx)
  );

  // Next-state decision: stall, continue current credit, or move to the next eligible class
  always_comb begin
    estado_d = estado_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    grand_d  = grand_q;
    pop_d    = 1'b0;
`ifdef QOS_STRICT_PRIO_EN
    resume_d = resume_q;
`endif
    if (FIFOP_ALMOST_FULL) begin
      pop_d = 1'b0;
    end
`ifdef QOS_STRICT_PRIO_EN
    else if (elig[0] && !(estado_q == SERVE && cur_q == 2'd0 && credit_q != '0)) begin
      cur_d    = 2'd0;
      grand_d  = onehot(2'd0);
      pop_d    = 1'b1;
      credit_d = cargaDe(2'd0);
      estado_d = SERVE;
      if (cur_q != 2'd0) begin
        resume_d = cur_q;
      end
    end
`endif
    else if (estado_q == SERVE && elig[cur_q] && credit_q != '0) begin
      pop_d    = 1'b1;
      credit_d = credit_q - CRED_WIDTH'(1);
    end else if (found) begin
      cur_d    = foundIdx;
      grand_d  = onehot(foundIdx);
      pop_d    = 1'b1;
      credit_d = cargaDe(foundIdx);
      estado_d = SERVE;
    end else begin
      pop_d    = 1'b0;
      credit_d = '0;
      estado_d = IDLE;
    end
  end

  // Arbiter state and registered outputs; reset clears everything immediately
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      estado_q <= IDLE;
      cur_q    <= 2'd3;
      credit_q <= '0;
      grand_q  <= '0;
      pop_q    <= 1'b0;
`ifdef QOS_STRICT_PRIO_EN
      resume_q <= 2'd3;
`endif
    end else begin
      estado_q <= estado_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
      grand_q  <= grand_d;
      pop_q    <= pop_d;
`ifdef QOS_STRICT_PRIO_EN
      resume_q <= resume_d;
`endif
    end
  end

  assign GRAND     = grand_q;
  assign POPDATOCF = pop_q;

endmodule

// File: tb/tb_arbitro_wrr.sv
// tb_arbitro_wrr: self-checking bench for arbitro_wrr (default build).
// Class FIFOs are modelled as word counts; a behavioural arbiter model
// predicts GRAND/POPDATOCF each cycle under directed and random stimulus.
module tb_arbitro_wrr;

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic [3:0] FIFO_EMPTY;
  logic [3:0] FIFO_ALMOST_EMPTY;
  logic       FIFOP_ALMOST_FULL;
  logic [3:0] GRAND;
  logic       POPDATOCF;

  int errors = 0;
  int checks = 0;

  int cnt[4];
  int wts[4] = '{4, 3, 2, 1};

  logic [3:0] mGrand;
  logic       mPop;
  int         mCur;
  int         mCred;
  bit         mServe;

  arbitro_wrr #(
    .W0(4), .W1(3), .W2(2), .W3(1), .CRED_WIDTH(4)
  ) dut (
    .CLK               (CLK),
    .RESET_L           (RESET_L),
    .FIFO_EMPTY        (FIFO_EMPTY),
    .FIFO_ALMOST_EMPTY (FIFO_ALMOST_EMPTY),
    .FIFOP_ALMOST_FULL (FIFOP_ALMOST_FULL),
    .GRAND             (GRAND),
    .POPDATOCF         (POPDATOCF)
  );

  // Free-running 10-unit clock
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic driveFlags();
    for (int i = 0; i < 4; i++) begin
      FIFO_EMPTY[i]        = (cnt[i] == 0);
      FIFO_ALMOST_EMPTY[i] = (cnt[i] <= 1);
    end
  endtask

  task automatic resetModel();
    mGrand = 4'b0000;
    mPop   = 1'b0;
    mCur   = 3;
    mCred  = 0;
    mServe = 1'b0;
  endtask

  // One clock: predict next outputs from current flags, clock, drain FIFOs, compare
  task automatic applyStimulus(input bit afull);
    logic [3:0] el;
    logic [3:0] nG;
    logic       nP;
    int         nCur, nCred, j;
    bit         nServe, hit;
    FIFOP_ALMOST_FULL = afull;
    driveFlags();
    for (int i = 0; i < 4; i++)
      el[i] = (cnt[i] != 0) && !(mPop && mGrand[i] && cnt[i] <= 1);
    nG = mGrand; nP = 1'b0; nCur = mCur; nCred = mCred; nServe = mServe;
    if (afull) begin
      nP = 1'b0;
    end else if (mServe && el[mCur] && mCred > 0) begin
      nP = 1'b1;
      nCred = mCred - 1;
    end else begin
      hit = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        j = (mCur + k) % 4;
        if (!hit && el[j]) begin
          hit = 1'b1; nCur = j; nG = 4'b0001 << j; nP = 1'b1;
          nCred = wts[j] - 1; nServe = 1'b1;
        end
      end
      if (!hit) begin
        nP = 1'b0; nCred = 0; nServe = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    if (mPop)
      for (int i = 0; i < 4; i++)
        if (mGrand[i] && cnt[i] > 0) cnt[i]--;
    mGrand = nG; mPop = nP; mCur = nCur; mCred = nCred; mServe = nServe;
    checkOutput("modelGrand", 32'(GRAND), 32'(mGrand));
    checkOutput("modelPop", 32'(POPDATOCF), 32'(mPop));
    driveFlags();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock
  task automatic doReset();
    RESET_L = 1'b0;
    #2;
    checkOutput("resetGrandAsync", 32'(GRAND), 32'h0);
    checkOutput("resetPopAsync", 32'(POPDATOCF), 32'h0);
    resetModel();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    FIFOP_ALMOST_FULL = 1'b0;
    driveFlags();
    @(posedge CLK);
    #1;
    checkOutput("resetGrandHeld", 32'(GRAND), 32'h0);
    RESET_L = 1'b1;
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    int patt[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    int pulses;
    logic [3:0] e;

    RESET_L = 1'b0;
    FIFOP_ALMOST_FULL = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    resetModel();
    driveFlags();
    @(posedge CLK);
    #1;
    doReset();

    // All empty after reset: nothing granted
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b0);
      checkOutput("idlePop", 32'(POPDATOCF), 32'h0);
      checkOutput("idleGrand", 32'(GRAND), 32'h0);
    end

    // WRR shares with every class backlogged
    for (int i = 0; i < 4; i++) cnt[i] = 200;
    for (int n = 0; n < 30; n++) begin
      applyStimulus(1'b0);
      e = 4'b0001 << patt[n % 10];
      checkOutput("wrrGrant", 32'(GRAND), 32'(e));
      checkOutput("wrrPop", 32'(POPDATOCF), 32'h1);
    end

    // Reset mid-stream, then all empty stays idle
    #3;
    doReset();
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b0);
      checkOutput("postResetPop", 32'(POPDATOCF), 32'h0);
    end

    // Last-word protection: single word in class 1
    cnt[1] = 1;
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b0);
      if (POPDATOCF === 1'b1) begin
        pulses++;
        checkOutput("lastWordGrant", 32'(GRAND), 32'h2);
      end
    end
    checkOutput("lastWordPulses", 32'(pulses), 32'd1);

    // Stall after two of class 0's four credits
    doReset();
    for (int i = 0; i < 4; i++) cnt[i] = 10;
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1'b0);
      checkOutput("stallPreGrant", 32'(GRAND), 32'h1);
    end
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1);
      checkOutput("stallPop", 32'(POPDATOCF), 32'h0);
      checkOutput("stallGrant", 32'(GRAND), 32'h1);
    end
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1'b0);
      checkOutput("stallResumeGrant", 32'(GRAND), 32'h1);
      checkOutput("stallResumePop", 32'(POPDATOCF), 32'h1);
    end
    applyStimulus(1'b0);
    checkOutput("stallNextClass", 32'(GRAND), 32'h2);

    // Class 0 empties after one pop: class 2 follows with no bubble
    doReset();
    cnt[0] = 1; cnt[1] = 0; cnt[2] = 5; cnt[3] = 5;
    applyStimulus(1'b0);
    checkOutput("emptyFirstGrant", 32'(GRAND), 32'h1);
    applyStimulus(1'b0);
    checkOutput("emptySwitchGrant", 32'(GRAND), 32'h4);
    checkOutput("emptySwitchPop", 32'(POPDATOCF), 32'h1);

    // Randomized traffic, refills, stalls and one mid-run reset
    doReset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) cnt[i] += $urandom_range(0, 3);
      if (n == 200) begin
        #2;
        doReset();
      end
      applyStimulus($urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
